ysyx_23060124_div: RTL and testbench
====================================

YSYX_23060124_DIV -- requirements
Module: ysyx_23060124_div

Interface
REQ-001: Parameter WIDTH, default 32, sets the operand and result width (equals ISA width).
REQ-002: The block SHALL have one clock and a synchronous, active-high reset.
REQ-003: clock  input  1  rising-edge clock for all state.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: in_valid  input  1  request present.
REQ-006: in_ready  output  1  block can accept a request.
REQ-007: dividend  input  WIDTH  numerator operand.
REQ-008: divisor  input  WIDTH  denominator operand.
REQ-009: div_signed  input  1  1 = two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-010: rem_sel  input  1  1 = return remainder, 0 = return quotient.
REQ-011: flush  input  1  abort any operation in flight.
REQ-012: out_valid  output  1  result present.
REQ-013: out_ready  input  1  consumer accepts result.
REQ-014: result  output  WIDTH  quotient or remainder.

Function
REQ-015: The FSM SHALL have the states IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016: Accept occurs on a rising edge with in_valid && in_ready && !flush; operands, div_signed and rem_sel SHALL be latched at accept and later input changes ignored.
REQ-017: Divisor zero at accept: go IDLE->DONE; quotient = all ones, remainder = dividend; out_valid one cycle after accept.
REQ-018: Signed overflow (div_signed, dividend = 1<<(WIDTH-1), divisor = all ones) at accept: go IDLE->DONE; quotient = dividend, remainder = 0; out_valid one cycle after accept.
REQ-019: Otherwise go IDLE->CALC with magnitudes latched (absolute values when div_signed, raw when unsigned) and iteration counter = 0.
REQ-020: CALC SHALL perform radix-2 restoring division, one quotient bit per cycle, for exactly WIDTH cycles; then CALC->DONE.
REQ-021: Normal-op latency: out_valid asserted exactly WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
REQ-022: Signed fixup: quotient negated when dividend and divisor signs differ; remainder takes the sign of the dividend; applied before or on entry to DONE.
REQ-023: result SHALL be the fixed-up quotient if rem_sel=0, else the remainder; result stays stable throughout DONE.
REQ-024: DONE->IDLE on an edge with out_ready=1; no new request is accepted in that same cycle (in_ready=0 in DONE).
REQ-025: While out_valid && !out_ready, the state and result SHALL hold indefinitely.
REQ-026: flush=1 on an edge SHALL force IDLE from any state; a pending result is discarded; flush overrides both a simultaneous accept and a simultaneous out handshake.
REQ-027: The counter SHALL be ceil(log2(WIDTH))+1 bits and SHALL not wrap; CALC exits on count == WIDTH-1.
REQ-028: All arithmetic SHALL be WIDTH+1 bits internally; the partial remainder never overflows.

Reset
REQ-029: reset=1 on an edge SHALL force state IDLE, counter 0, result 0 and out_valid 0 next cycle, regardless of in_valid or flush.
REQ-030: reset SHALL take priority over flush and accept; a reset mid-CALC abandons the operation with no result produced.
REQ-031: In the first cycle after reset deasserts, in_ready=1 and out_valid=0.

Verification
REQ-032: Unsigned: dividend=100, divisor=7, div_signed=0, rem_sel=0 -> result 14 with out_valid exactly 33 cycles after accept; rem_sel=1 -> result 2.
REQ-033: Signed: dividend=0xFFFFFFF9 (-7), divisor=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-034: Divide by zero: 5/0 signed and unsigned -> quotient 0xFFFFFFFF, remainder 5, out_valid 1 cycle after accept.
REQ-035: Overflow: 0x80000000 / 0xFFFFFFFF, signed -> quotient 0x80000000, remainder 0, 1-cycle latency; same operands unsigned -> quotient 0, remainder 0x80000000, 33 cycles.
REQ-036: Backpressure: out_ready held 0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-037: Abort: flush at CALC cycle 10 -> IDLE next cycle with no out_valid; repeat with reset instead of flush -> same; the next request then completes correctly.

Source files
------------

// File: rtl/ysyx_23060124_div_if.sv
// Request/response handshake bundle for the iterative divider.
// Slave is the divider side; master is the requester/consumer side.
interface ysyx_23060124_div_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_signed;
  logic             rem_sel;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport slave (
    input  in_valid, dividend, divisor, div_signed, rem_sel, flush, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, dividend, divisor, div_signed, rem_sel, flush, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/ysyx_23060124_div.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Divide-by-zero and signed overflow short-circuit straight to DONE.
module ysyx_23060124_div #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_23060124_div_if.slave   io
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             accept;
  logic             is_ovf;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;

    accept  = (state_q == IDLE) && io.in_valid && !io.flush;
    dvd_abs = (io.div_signed && io.dividend[WIDTH-1]) ? -io.dividend : io.dividend;
    dvs_abs = (io.div_signed && io.divisor[WIDTH-1])  ? -io.divisor  : io.divisor;
    is_ovf  = io.div_signed && (io.dividend == {1'b1, {(WIDTH-1){1'b0}}})
              && (io.divisor == '1);

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shift.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rem_sel_d = io.rem_sel;
          if (io.divisor == '0) begin
            result_d = io.rem_sel ? io.dividend : '1;
            state_d  = DONE;
          end else if (is_ovf) begin
            result_d = io.rem_sel ? '0 : io.dividend;
            state_d  = DONE;
          end else begin
            neg_quo_d = io.div_signed && (io.dividend[WIDTH-1] ^ io.divisor[WIDTH-1]);
            neg_rem_d = io.div_signed && io.dividend[WIDTH-1];
            quo_d     = dvd_abs;
            dvs_d     = dvs_abs;
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
          if (rem_sel_q) result_d = neg_rem_q ? -rem_d : rem_d;
          else           result_d = neg_quo_q ? -quo_d : quo_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (io.flush) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      result_q  <= result_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = result_q;
endmodule

// File: tb/tb_ysyx_23060124_div.sv
// Directed bench for ysyx_23060124_div with hand-computed results and latencies.
module tb_ysyx_23060124_div;
  localparam int WIDTH = 32;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  ysyx_23060124_div_if #(.WIDTH(WIDTH)) io ();

  ysyx_23060124_div #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic sgn, input logic rs);
    int guard;
    guard = 0;
    while (!io.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    io.in_valid   = 1'b1;
    io.dividend   = dvd;
    io.divisor    = dvs;
    io.div_signed = sgn;
    io.rem_sel    = rs;
    tick();
    // Scramble operands after accept: the divider must use the latched copies.
    io.in_valid   = 1'b0;
    io.dividend   = 32'h1234_5678;
    io.divisor    = 32'h0000_0003;
    io.div_signed = ~sgn;
    io.rem_sel    = ~rs;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!io.out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic sgn, input logic rs,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    start_op(dvd, dvs, sgn, rs);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, io.result, exp_res);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, io.in_ready, io.out_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic stable;

    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    io.in_valid   = 1'b1;
    io.dividend   = 32'd9;
    io.divisor    = 32'd3;
    io.div_signed = 1'b0;
    io.rem_sel    = 1'b0;
    io.flush      = 1'b1;
    io.out_ready  = 1'b0;
    tick();
    tick();
    io.in_valid = 1'b0;
    io.flush    = 1'b0;
    reset       = 1'b0;
    check("reset_hs", {30'd0, io.in_ready, io.out_valid}, 32'b10);
    check("reset_res", io.result, 32'd0);

    run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 33);
    run_op("urem_100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 33);
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 33);
    run_op("srem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 33);
    run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 33);
    run_op("srem_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1, 33);
    run_op("sdiv_5_0", 32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1);
    run_op("srem_5_0", 32'd5, 32'd0, 1'b1, 1'b1, 32'd5, 1);
    run_op("udiv_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1);
    run_op("urem_5_0", 32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 1);
    run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1);
    run_op("srem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1);
    run_op("udiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 33);
    run_op("urem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 33);
    run_op("udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 33);

    // Backpressure: hold DONE for 10 cycles.
    start_op(32'd1000, 32'd33, 1'b0, 1'b0);
    wait_done(lat);
    check("bp_lat", 32'(lat), 32'd33);
    held   = io.result;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!io.out_valid || io.in_ready || io.result !== held) stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_res", io.result, 32'd30);
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    check("bp_release", {30'd0, io.in_ready, io.out_valid}, 32'b10);

    // Flush blocks a simultaneous accept.
    io.in_valid = 1'b1;
    io.dividend = 32'd8;
    io.divisor  = 32'd2;
    io.flush    = 1'b1;
    tick();
    io.in_valid = 1'b0;
    io.flush    = 1'b0;
    check("flush_acc", {30'd0, io.in_ready, io.out_valid}, 32'b10);

    // Abort mid-calculation with flush, then with reset.
    for (int k = 0; k < 2; k++) begin
      start_op(32'd77, 32'd5, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      if (k == 0) io.flush = 1'b1;
      else        reset    = 1'b1;
      tick();
      io.flush = 1'b0;
      reset    = 1'b0;
      check(k == 0 ? "flush_idle" : "rst_idle", {30'd0, io.in_ready, io.out_valid}, 32'b10);
      stable = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (io.out_valid) stable = 1'b0;
      end
      check(k == 0 ? "flush_noout" : "rst_noout", {31'd0, stable}, 32'd1);
    end
    check("rst_res0", io.result, 32'd0);
    run_op("after_abort", 32'd77, 32'd5, 1'b0, 1'b1, 32'd2, 33);

    // Flush discards a pending result.
    start_op(32'd9, 32'd0, 1'b0, 1'b0);
    check("flush_done_pre", {31'd0, io.out_valid}, 32'd1);
    io.flush     = 1'b1;
    io.out_ready = 1'b1;
    tick();
    io.flush     = 1'b0;
    io.out_ready = 1'b0;
    check("flush_done", {30'd0, io.in_ready, io.out_valid}, 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
